// File: rtl/ifu_prefetch.sv
// ifu_prefetch: fetch-PC owner issuing single-outstanding imem reads into a DEPTH-entry FIFO for ID
module ifu_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] ADDR_LO  = 32'h0000_3000,
  parameter logic [31:0] ADDR_HI  = 32'h0000_6ffc,
  parameter int          DEPTH    = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Req,
  input  logic        ID_eret,
  input  logic [31:0] EPC,
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_adel
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HALT} state_t;
  state_t state, state_n;
  logic [31:0] fetch_pc, req_pc, target, push_pc;
  logic [31:0] pc_q [DEPTH];
  logic [31:0] instr_q [DEPTH];
  logic        adel_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic redir, kill, bad, space, issue, grant, push_bad, push, pop;
  assign redir     = ID_eret | Req | br_valid;
  assign kill      = Reset | redir;
  assign target    = ID_eret ? EPC : Req ? EXC_PC : br_pc;
  assign bad       = (fetch_pc[1:0] != 2'b00) | (fetch_pc < ADDR_LO) | (fetch_pc > ADDR_HI);
  assign space     = count < (AW+1)'(DEPTH);
  assign issue     = (state == IDLE) & space & !bad;
  assign imem_req  = ((state == REQ) | issue) & !kill;
  assign imem_addr = fetch_pc;
  assign grant     = imem_req & imem_gnt;
  assign push_bad  = (state == IDLE) & space & bad;
  assign push      = ((imem_rvalid & ((state == WAIT) | grant)) | push_bad) & !kill;
  assign push_pc   = (push_bad | grant) ? fetch_pc : req_pc;
  assign pop       = out_valid & out_ready & !kill;
  assign out_valid = count != '0;
  assign out_pc    = out_valid ? pc_q[rd_ptr] : '0;
  assign out_instr = out_valid ? instr_q[rd_ptr] : '0;
  assign out_adel  = out_valid & adel_q[rd_ptr];
  // A read still in flight at redirect must be swallowed by DRAIN, unless it lands this very cycle
  always_comb begin
    state_n = redir ? (((state == WAIT) | (state == DRAIN)) & !imem_rvalid ? DRAIN : IDLE)
            : grant ? (imem_rvalid ? IDLE : WAIT)
            : (state == IDLE) ? (issue ? REQ : push_bad ? HALT : IDLE)
            : ((state == WAIT) | (state == DRAIN)) ? (imem_rvalid ? IDLE : state)
            : state;
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redir) begin
      state    <= state_n;
      fetch_pc <= target;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state  <= state_n;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_q[wr_ptr]    <= push_pc;
      instr_q[wr_ptr] <= push_bad ? '0 : imem_rdata;
      adel_q[wr_ptr]  <= push_bad;
    end
  end
endmodule
